i2c_master_writer: RTL and testbench
====================================

Name: i2c_master_writer

Overview:
- Parametrised I2C master write engine that replaces the fixed single-byte result transmitter in the FPU state machine path.
- Sends a 7-bit address with W=0, then DATA_BYTES payload bytes, most significant byte first, with per-byte ACK checking.
- Reports busy, done and nack status.
- Sits between the FP result register (for example a 32-bit add/sub result) and the board-level i2c_sda/i2c_scl pins.

Parameters:
- DATA_BYTES, 4, number of payload bytes per transaction (1..16).
- CLK_DIV, 4, system clocks per SCL quarter-period (>=2). SCL period = 4*CLK_DIV clocks.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request pulse. Accepted only when busy=0.
- slave_addr  input  7  target address, latched on accept.
- data_in  input  8*DATA_BYTES  payload, latched on accept. Byte [8*DATA_BYTES-1 -: 8] is sent first.
- busy  output  1  high from the cycle after accept until the done cycle, inclusive.
- done  output  1  one-cycle pulse at the end of every transaction.
- nack  output  1  valid with done. High if any ACK bit was sampled as 1.
- i2c_sda  inout  1  open-drain: drives 0 or releases to Z. Read back for ACK.
- i2c_scl  output  1  push-pull clock, idles 1.

Behaviour:
- Reset, applied at any time including mid-transfer, sets the following on the next edge:
  - busy=0, done=0, nack=0.
  - i2c_scl=1, i2c_sda released.
  - FSM=IDLE, divider and all counters cleared.
- Quarter tick: an internal counter 0..CLK_DIV-1 pulses qtick at wrap. Every phase below lasts exactly one quarter (CLK_DIV clocks).
- FSM states: IDLE, START, ADDR, ADDR_ACK, DATA, DATA_ACK, STOP, DONE.
- IDLE:
  - SCL=1, SDA released.
  - If start=1, latch inputs and go to START. The divider restarts at 0.
  - start while busy is ignored, with no queueing.
- START, 4 quarters:
  - Q0: SDA released, SCL high.
  - Q1 and Q2: SDA=0, SCL high.
  - Q3: SCL low.
- Bit slot, 4 quarters:
  - Q0: SCL low, SDA updated.
  - Q1: SCL low.
  - Q2 and Q3: SCL high.
  - Read bits are sampled on the last clock of Q2.
- ADDR: 8 bit slots carrying {slave_addr, 1'b0}, MSB first. Then ADDR_ACK, one slot with SDA released.
- ACK handling: if the sampled SDA is 1, set nack and go to STOP, skipping the remaining bytes. Otherwise go to DATA.
- DATA: 8 slots per byte. The byte counter counts 0..DATA_BYTES-1, each byte is followed by DATA_ACK, and the same nack rule applies.
  - After the ACK of the last byte, go to STOP.
- STOP, 4 quarters:
  - Q0: SCL low, SDA=0.
  - Q1: SCL high, SDA=0.
  - Q2 and Q3: SCL high, SDA released.
- DONE: one clock with done=1 and nack held. Then IDLE, busy=0. nack stays valid until the next accept.
- Latency with no NACK: 4+36*(1+DATA_BYTES)+4 quarters, plus 1 DONE clock.
  - Defaults: 188 quarters = 752 clocks after accept, so done rises in clock 753.
- Simultaneous events:
  - Reset beats start.
  - start in the same cycle as done is ignored. It must be re-asserted once busy=0.
- SDA is never driven to 1. Any 1 bit releases the line to Z.

Decomposition:
- Package i2c_pkg:
  - state enum (IDLE..DONE).
  - quarter-index constants Q0..Q3.
  - I2C_WRITE=1'b0.
  - SLOT_QUARTERS=4, BITS_PER_SLOT=9.
- Sub-module i2c_qtick_gen:
  - Parameter CLK_DIV. Inputs clk, reset, clear. Outputs qtick and a 2-bit quarter index.
- i2c_master_writer holds the FSM, shift register, bit counter and byte counter.

Test Plan:
- Basic write: slave_addr=7'b0001101, data_in=32'h41000000, start for 1 clock, slave ACKs all bytes.
  - Slave data_out shows 8'h41, 8'h00, 8'h00, 8'h00 in order.
  - done fires once at clock 753 after accept, nack=0.
- Address NACK: slave address 7'b0001110 with master addressing 7'b0001101.
  - STOP follows the first ACK slot.
  - done after (4+36+4)*4+1 = 177 clocks, nack=1, no data byte is seen on the bus.
- Data NACK on byte 2: the slave releases the ACK for the second byte.
  - Exactly 2 bytes are transferred, then STOP, nack=1.
- Back-to-back: start is held high through busy, and a new start is applied after done.
  - The first transaction is unaffected. The second data 32'h40000000 is received intact.
- Reset mid-transfer at clock 300 during DATA.
  - On the next edge: SCL=1, SDA=Z, busy=0, done=0.
  - A subsequent start completes a normal transfer.
- Parameter sweep: DATA_BYTES=1, CLK_DIV=2.
  - SCL period is 8 clocks. done at (4+72+4)*2+1 = 161 clocks. One byte is received.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C master write engine.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    ADDR,
    ADDR_ACK,
    DATA,
    DATA_ACK,
    STOP,
    DONE
  } state_e;

  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

  localparam logic I2C_WRITE     = 1'b0;
  localparam int   SLOT_QUARTERS = 4;
  localparam int   BITS_PER_SLOT = 9;

endpackage

// File: rtl/i2c_qtick_gen.sv
// Quarter-period tick generator: pulses qtick every CLK_DIV clocks and
// tracks which quarter of the current SCL slot is active.
module i2c_qtick_gen
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  output logic       qtick,
  output logic [1:0] quarter
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] div_q, div_d;
  logic [1:0]    quarter_q, quarter_d;

  // Divider wraps at CLK_DIV-1; quarter index advances on each wrap.
  always_comb begin
    qtick     = !clear && (div_q == CW'(CLK_DIV - 1));
    div_d     = qtick ? '0 : div_q + 1'b1;
    quarter_d = quarter_q;
    if (qtick) begin
      quarter_d = (quarter_q == 2'(SLOT_QUARTERS - 1)) ? Q0 : quarter_q + 2'd1;
    end
    if (clear) begin
      div_d     = '0;
      quarter_d = Q0;
    end
  end

  // Counter registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q     <= '0;
      quarter_q <= Q0;
    end else begin
      div_q     <= div_d;
      quarter_q <= quarter_d;
    end
  end

  assign quarter = quarter_q;

endmodule

// File: rtl/i2c_master_writer.sv
// I2C master write engine: START, address+W, DATA_BYTES payload bytes
// MSB first with ACK checking after each byte, then STOP.
module i2c_master_writer
  import i2c_pkg::*;
#(
  parameter int DATA_BYTES = 4,
  parameter int CLK_DIV    = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [6:0]              slave_addr,
  input  logic [8*DATA_BYTES-1:0] data_in,
  output logic                    busy,
  output logic                    done,
  output logic                    nack,
  inout  wire                     i2c_sda,
  output logic                    i2c_scl
);

  localparam int DW  = 8 * DATA_BYTES;
  localparam int BCW = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;

  state_e          state_q, state_d;
  logic [DW-1:0]   data_q, data_d;
  logic [7:0]      shift_q, shift_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [BCW-1:0]  byte_cnt_q, byte_cnt_d;
  logic            ack_q, ack_d;
  logic            nack_q, nack_d;

  logic            qtick;
  logic [1:0]      quarter;
  logic            div_clear;
  logic            slot_end;
  logic            sample_now;
  logic            last_bit;
  logic            last_byte;
  logic            sda_low;

  i2c_qtick_gen #(.CLK_DIV(CLK_DIV)) u_qtick (
    .clk     (clk),
    .reset   (reset),
    .clear   (div_clear),
    .qtick   (qtick),
    .quarter (quarter)
  );

  assign slot_end   = qtick && (quarter == Q3);
  assign sample_now = qtick && (quarter == Q2);
  assign last_bit   = (bit_cnt_q == 3'(BITS_PER_SLOT - 2));
  assign last_byte  = (byte_cnt_q == BCW'(DATA_BYTES - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; every phase change happens at the end of a slot.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (start) state_d = START;
      START:    if (slot_end) state_d = ADDR;
      ADDR:     if (slot_end && last_bit) state_d = ADDR_ACK;
      ADDR_ACK: if (slot_end) state_d = ack_q ? STOP : DATA;
      DATA:     if (slot_end && last_bit) state_d = DATA_ACK;
      DATA_ACK: if (slot_end) state_d = (ack_q || last_byte) ? STOP : DATA;
      STOP:     if (slot_end) state_d = DONE;
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Datapath update: latch on accept, shift bits, sample ACKs, load bytes.
  always_comb begin
    data_d     = data_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    ack_d      = ack_q;
    nack_d     = nack_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          data_d     = data_in;
          shift_d    = {slave_addr, I2C_WRITE};
          bit_cnt_d  = '0;
          byte_cnt_d = '0;
          ack_d      = 1'b0;
          nack_d     = 1'b0;
        end
      end
      ADDR, DATA: begin
        if (slot_end) begin
          shift_d   = {shift_q[6:0], 1'b0};
          bit_cnt_d = bit_cnt_q + 3'd1;
        end
      end
      ADDR_ACK, DATA_ACK: begin
        if (sample_now) begin
          ack_d = i2c_sda;
        end
        if (slot_end) begin
          if (ack_q) begin
            nack_d = 1'b1;
          end else begin
            shift_d = data_q[DW-1 -: 8];
            data_d  = data_q << 8;
            if (state_q == DATA_ACK) begin
              byte_cnt_d = byte_cnt_q + 1'b1;
            end
          end
        end
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q     <= '0;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      ack_q      <= 1'b0;
      nack_q     <= 1'b0;
    end else begin
      data_q     <= data_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      ack_q      <= ack_d;
      nack_q     <= nack_d;
    end
  end

  // Bus waveform and status outputs decoded from state and quarter.
  always_comb begin
    i2c_scl   = 1'b1;
    sda_low   = 1'b0;
    busy      = (state_q != IDLE);
    done      = (state_q == DONE);
    div_clear = (state_q == IDLE) || (state_q == DONE);
    case (state_q)
      START: begin
        i2c_scl = (quarter != Q3);
        sda_low = (quarter != Q0);
      end
      ADDR, DATA: begin
        i2c_scl = (quarter == Q2) || (quarter == Q3);
        sda_low = ~shift_q[7];
      end
      ADDR_ACK, DATA_ACK: begin
        i2c_scl = (quarter == Q2) || (quarter == Q3);
        sda_low = 1'b0;
      end
      STOP: begin
        i2c_scl = (quarter != Q0);
        sda_low = (quarter == Q0) || (quarter == Q1);
      end
      default: ;
    endcase
  end

  // Open drain: only ever pull low, a 1 releases the line.
  assign i2c_sda = sda_low ? 1'b0 : 1'bz;
  assign nack    = nack_q;

endmodule

// File: tb/tb_i2c_master_writer.sv
// Self-checking bench for i2c_master_writer with a bus-level slave model.
module tb_i2c_master_writer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  logic        start0 = 1'b0, start1 = 1'b0;
  logic [6:0]  addr0 = '0, addr1 = '0;
  logic [31:0] data0 = '0;
  logic [7:0]  data1 = '0;
  logic        busy0, done0, nack0, scl0;
  logic        busy1, done1, nack1, scl1;
  wire         sda0, sda1;

  pullup (sda0);
  pullup (sda1);

  int n_checks = 0;
  int n_pass   = 0;

  // Slave model state
  int          sel = 0;
  logic        slave_low = 1'b0;
  logic [6:0]  my_addr = '0;
  int          nack_idx = 0;
  logic [7:0]  rx[$];
  logic [7:0]  exp_q[$];
  int          stop_cnt = 0;
  int          cyc_cnt = 0;
  int          last_rise = 0;
  int          rise_num = 0;
  int          scl_period = 0;
  logic        scl_prev = 1'b1, sda_prev = 1'b1;
  logic        scl_now, sda_now;
  logic        in_frame = 1'b0, ack_drv = 1'b0;
  int          bit_idx = 0, byte_idx = 0;
  logic [7:0]  shreg = '0;

  always #5 clk = ~clk;

  assign sda0 = (sel == 0 && slave_low) ? 1'b0 : 1'bz;
  assign sda1 = (sel == 1 && slave_low) ? 1'b0 : 1'bz;

  i2c_master_writer #(.DATA_BYTES(4), .CLK_DIV(4)) dut0 (
    .clk(clk), .reset(reset), .start(start0), .slave_addr(addr0), .data_in(data0),
    .busy(busy0), .done(done0), .nack(nack0), .i2c_sda(sda0), .i2c_scl(scl0)
  );

  i2c_master_writer #(.DATA_BYTES(1), .CLK_DIV(2)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .slave_addr(addr1), .data_in(data1),
    .busy(busy1), .done(done1), .nack(nack1), .i2c_sda(sda1), .i2c_scl(scl1)
  );

  // Oversampling slave: decodes START/STOP, collects bytes, drives ACK/NACK.
  always @(negedge clk) begin
    cyc_cnt++;
    scl_now = (sel == 0) ? scl0 : scl1;
    sda_now = (sel == 0) ? sda0 : sda1;
    if (reset) begin
      slave_low = 1'b0;
      in_frame  = 1'b0;
      ack_drv   = 1'b0;
      bit_idx   = 0;
    end else if (scl_prev && scl_now && sda_prev && !sda_now) begin
      in_frame = 1'b1; bit_idx = 0; byte_idx = 0; ack_drv = 1'b0;
      slave_low = 1'b0; rise_num = 0; last_rise = 0;
    end else if (scl_prev && scl_now && !sda_prev && sda_now) begin
      if (in_frame) stop_cnt++;
      in_frame = 1'b0;
    end else if (in_frame && !scl_prev && scl_now) begin
      rise_num++;
      if (rise_num == 2) scl_period = cyc_cnt - last_rise;
      last_rise = cyc_cnt;
      if (bit_idx < 8) begin
        shreg = {shreg[6:0], sda_now};
        bit_idx++;
        if (bit_idx == 8) rx.push_back(shreg);
      end
    end else if (in_frame && scl_prev && !scl_now) begin
      if (bit_idx == 8 && !ack_drv) begin
        ack_drv = 1'b1;
        if (byte_idx == 0) slave_low = (shreg[7:1] == my_addr);
        else               slave_low = (byte_idx != nack_idx);
      end else if (ack_drv) begin
        ack_drv = 1'b0; slave_low = 1'b0; bit_idx = 0; byte_idx++;
      end
    end
    scl_prev = scl_now;
    sda_prev = sda_now;
  end

  // Reference model: bytes seen on the bus, final nack and done latency.
  task automatic model_txn(input int nbytes, input int cdiv, input logic [6:0] maddr,
                           input logic [6:0] saddr, input logic [31:0] d, input int nidx,
                           output int lat, output logic nk);
    int sent = 0;
    exp_q.delete();
    exp_q.push_back({maddr, 1'b0});
    nk = 1'b0;
    if (maddr != saddr) begin
      nk = 1'b1;
    end else begin
      for (int i = 0; i < nbytes; i++) begin
        exp_q.push_back(d[8*(nbytes-1-i) +: 8]);
        sent++;
        if (i + 1 == nidx) begin
          nk = 1'b1;
          break;
        end
      end
    end
    lat = (8 + 36 * (1 + sent)) * cdiv + 1;
  endtask

  // Issues one start and waits (bounded) for done; lat=0 means timeout.
  task automatic run_txn(input int s, input logic [6:0] maddr, input logic [31:0] d,
                         input bit hold, output int lat, output logic nk, output int gaps);
    sel = s;
    @(negedge clk);
    rx.delete();
    if (s == 0) begin addr0 = maddr; data0 = d; start0 = 1'b1; end
    else begin addr1 = maddr; data1 = d[7:0]; start1 = 1'b1; end
    @(posedge clk); #1;
    if (!hold) begin start0 = 1'b0; start1 = 1'b0; end
    lat = 0; nk = 1'b0; gaps = 0;
    for (int c = 1; c <= 4000; c++) begin
      if (hold && c == 100) begin data0 = ~d; addr0 = ~maddr; end
      if (((s == 0) ? done0 : done1) === 1'b1) begin
        lat = c;
        nk = (s == 0) ? nack0 : nack1;
        break;
      end
      if (((s == 0) ? busy0 : busy1) !== 1'b1) gaps++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    n_checks++; if (busy0 !== 1'b0) $display("[TB] FAIL reset_busy got=%b want=0", busy0); else n_pass++;
    n_checks++; if (done0 !== 1'b0) $display("[TB] FAIL reset_done got=%b want=0", done0); else n_pass++;
    n_checks++; if (nack0 !== 1'b0) $display("[TB] FAIL reset_nack got=%b want=0", nack0); else n_pass++;
    n_checks++; if (scl0 !== 1'b1) $display("[TB] FAIL reset_scl got=%b want=1", scl0); else n_pass++;
    n_checks++; if (sda0 !== 1'b1) $display("[TB] FAIL reset_sda got=%b want=1(released)", sda0); else n_pass++;
    n_checks++; if (scl1 !== 1'b1) $display("[TB] FAIL reset_scl1 got=%b want=1", scl1); else n_pass++;
  endtask

  // Full comparison of a finished transaction against the model.
  task automatic check_txn(input string tag, input int s, input logic [6:0] maddr,
                           input logic [31:0] d, input bit hold);
    int lat, elat, gaps, stops_before;
    logic nk, enk;
    stops_before = stop_cnt;
    model_txn(s ? 1 : 4, s ? 2 : 4, maddr, my_addr, d, nack_idx, elat, enk);
    run_txn(s, maddr, d, hold, lat, nk, gaps);
    n_checks++; if (lat !== elat) $display("[TB] FAIL %s_latency got=%0d want=%0d", tag, lat, elat); else n_pass++;
    n_checks++; if (nk !== enk) $display("[TB] FAIL %s_nack got=%b want=%b", tag, nk, enk); else n_pass++;
    n_checks++; if (gaps !== 0) $display("[TB] FAIL %s_busy_gaps got=%0d want=0", tag, gaps); else n_pass++;
    n_checks++; if (rx.size() !== exp_q.size()) $display("[TB] FAIL %s_byte_count got=%0d want=%0d", tag, rx.size(), exp_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (i >= rx.size() || rx[i] !== exp_q[i])
        $display("[TB] FAIL %s_byte%0d got=%h want=%h", tag, i, (i < rx.size()) ? rx[i] : 8'h00, exp_q[i]);
      else n_pass++;
    end
    n_checks++; if (stop_cnt !== stops_before + 1) $display("[TB] FAIL %s_stop got=%0d want=%0d", tag, stop_cnt - stops_before, 1); else n_pass++;
    if (!hold) begin
      @(posedge clk); #1;
      n_checks++; if (((s == 0) ? done0 : done1) !== 1'b0) $display("[TB] FAIL %s_done_pulse got=1 want=0", tag); else n_pass++;
      n_checks++; if (((s == 0) ? busy0 : busy1) !== 1'b0) $display("[TB] FAIL %s_idle_busy got=1 want=0", tag); else n_pass++;
    end
  endtask

  task automatic test_basic_write();
    my_addr = 7'b0001101; nack_idx = 0;
    check_txn("basic", 0, 7'b0001101, 32'h41000000, 1'b0);
    n_checks++; if (scl_period !== 16) $display("[TB] FAIL basic_scl_period got=%0d want=16", scl_period); else n_pass++;
  endtask

  task automatic test_addr_nack();
    my_addr = 7'b0001110; nack_idx = 0;
    check_txn("addr_nack", 0, 7'b0001101, $urandom, 1'b0);
  endtask

  task automatic test_data_nack();
    my_addr = 7'b0001101; nack_idx = 2;
    check_txn("data_nack", 0, 7'b0001101, $urandom, 1'b0);
  endtask

  task automatic test_back_to_back();
    my_addr = 7'b0001101; nack_idx = 0;
    check_txn("b2b_first", 0, 7'b0001101, 32'h41000000, 1'b1);
    @(posedge clk); #1;
    n_checks++; if (busy0 !== 1'b0) $display("[TB] FAIL b2b_done_cycle_start got=%b want=0", busy0); else n_pass++;
    start0 = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (busy0 !== 1'b0) $display("[TB] FAIL b2b_no_queue got=%b want=0", busy0); else n_pass++;
    check_txn("b2b_second", 0, 7'b0001101, 32'h40000000, 1'b0);
  endtask

  task automatic test_reset_mid_transfer();
    my_addr = 7'b0001101; nack_idx = 0; sel = 0;
    @(negedge clk);
    addr0 = 7'b0001101; data0 = $urandom; start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    repeat (299) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (scl0 !== 1'b1) $display("[TB] FAIL midreset_scl got=%b want=1", scl0); else n_pass++;
    n_checks++; if (sda0 !== 1'b1) $display("[TB] FAIL midreset_sda got=%b want=1(released)", sda0); else n_pass++;
    n_checks++; if (busy0 !== 1'b0) $display("[TB] FAIL midreset_busy got=%b want=0", busy0); else n_pass++;
    n_checks++; if (done0 !== 1'b0) $display("[TB] FAIL midreset_done got=%b want=0", done0); else n_pass++;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    check_txn("after_reset", 0, 7'b0001101, $urandom, 1'b0);
  endtask

  task automatic test_param_sweep();
    my_addr = 7'($urandom); nack_idx = 0;
    check_txn("sweep", 1, my_addr, $urandom, 1'b0);
    n_checks++; if (scl_period !== 8) $display("[TB] FAIL sweep_scl_period got=%0d want=8", scl_period); else n_pass++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      int s;
      logic [6:0] maddr;
      s = (i % 3 == 2) ? 1 : 0;
      my_addr = 7'($urandom);
      maddr = ($urandom_range(0, 3) == 0) ? (my_addr ^ 7'h05) : my_addr;
      nack_idx = $urandom_range(0, s ? 1 : 4);
      check_txn($sformatf("rand%0d", i), s, maddr, $urandom, 1'b0);
    end
  endtask

  // Global time bound so the bench always terminates.
  initial begin
    #5000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    test_basic_write();
    test_addr_nack();
    test_data_nack();
    test_back_to_back();
    test_reset_mid_transfer();
    test_param_sweep();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
